// File: rtl/fir_pkg.sv
// fir_pkg: shared types and defaults for the FIR MAC sequencer.
// Holds the sequencer state enum, default sizes and modular address math.
package fir_pkg;

  localparam int FIR_DEPTH_DEF   = 16;
  localparam int DATA_WIDTH_DEF  = 24;
  localparam int MAC_LATENCY_DEF = 3;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    ISSUE,
    DRAIN,
    DONE
  } fir_seq_state_t;

  // (a - b) mod depth for a, b < depth; explicit compare so depth
  // need not be a power of two.
  function automatic int unsigned fir_wrap_sub(
    input int unsigned a,
    input int unsigned b,
    input int unsigned depth
  );
    if (a >= b) begin
      return a - b;
    end
    return a + depth - b;
  endfunction

endpackage

// File: rtl/fir_seq_delay_pipe.sv
// fir_seq_delay_pipe: MAC_LATENCY-deep shift register carrying
// {issue, first_tap} from address issue to the accumulator strobes.
// Ports: i_clk/i_rst (sync, active-high), i_en (shift enable),
//   i_issue/i_first (pipe input), o_issue/o_first (pipe output),
//   o_busy (an issue is still in flight ahead of the output stage).
module fir_seq_delay_pipe #(
  parameter int MAC_LATENCY = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_issue,
  input  logic i_first,
  output logic o_issue,
  output logic o_first,
  output logic o_busy
);

  logic [MAC_LATENCY-1:0] issue_q;
  logic [MAC_LATENCY-1:0] first_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      issue_q <= '0;
      first_q <= '0;
    end else if (i_en) begin
      issue_q[0] <= i_issue;
      first_q[0] <= i_first;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        issue_q[i] <= issue_q[i-1];
        first_q[i] <= first_q[i-1];
      end
    end
  end

  assign o_issue = issue_q[MAC_LATENCY-1];
  assign o_first = first_q[MAC_LATENCY-1];

  generate
    if (MAC_LATENCY > 1) begin : g_busy
      assign o_busy = |issue_q[MAC_LATENCY-2:0];
    end else begin : g_nobusy
      assign o_busy = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control sequencer for a time-multiplexed FIR MAC.
// Clears the delay line, then per accepted sample: write, issue all
// taps, drain the MAC pipe, pulse result. Optional macro:
// FIR_MAC_SEQUENCER_OVERRUN_EN adds o_overrun / o_overrun_cnt.
// Ports: i_clk, i_rst (sync active-high), i_en (freeze when low),
//   i_sample_valid / o_ready (sample handshake),
//   o_wr_en / o_wr_zero / o_wr_addr (delay-line write),
//   o_issue / o_rd_addr / o_coef_addr (tap reads),
//   o_mac_clr / o_mac_en (accumulator strobes), o_result_valid.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FIR_DEPTH   = FIR_DEPTH_DEF,
  parameter int MAC_LATENCY = MAC_LATENCY_DEF,
  localparam int AW         = $clog2(FIR_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_sample_valid,
  output logic          o_ready,
  output logic          o_wr_en,
  output logic          o_wr_zero,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_issue,
  output logic [AW-1:0] o_rd_addr,
  output logic [AW-1:0] o_coef_addr,
  output logic          o_mac_clr,
  output logic          o_mac_en,
  output logic          o_result_valid
`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
  ,
  output logic          o_overrun,
  output logic [7:0]    o_overrun_cnt
`endif
);

  localparam logic [AW-1:0] TAP_LAST = AW'(FIR_DEPTH - 1);

  generate
    if (DATA_WIDTH < 1 || FIR_DEPTH < 2 || MAC_LATENCY < 1) begin : g_bad
      $error("fir_mac_sequencer: illegal parameters");
    end
  endgenerate

  fir_seq_state_t state_q, state_d;
  logic [AW-1:0]  tap_q, tap_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;

  logic          ready_r;
  logic          wr_en_r;
  logic          wr_zero_r;
  logic          issue_r;
  logic          result_r;
  logic [AW-1:0] wr_addr_r;
  logic [AW-1:0] rd_addr_r;

  logic accept;
  logic gate;
  logic first_tap;
  logic pipe_issue;
  logic pipe_first;
  logic pipe_busy;

  // Strobes are qualified by enable and masked while reset is applied.
  assign gate      = i_en & ~i_rst;
  assign accept    = i_sample_valid & ready_r;
  assign first_tap = issue_r & (tap_q == '0);

  // State register; everything holds while i_en is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= CLEAR;
      tap_q    <= '0;
      wr_ptr_q <= '0;
    end else if (i_en) begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Next-state logic. tap_q doubles as the clear-pass address counter.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    wr_ptr_d = wr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        if (tap_q == TAP_LAST) begin
          state_d = IDLE;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        if (tap_q == TAP_LAST) begin
          state_d  = DRAIN;
          tap_d    = '0;
          wr_ptr_d = (wr_ptr_q == TAP_LAST) ? '0 : wr_ptr_q + 1'b1;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      DRAIN: begin
        // Leave once only the final product sits in the output stage.
        if (!pipe_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = accept ? WRITE : IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    ready_r   = 1'b0;
    wr_en_r   = 1'b0;
    wr_zero_r = 1'b0;
    issue_r   = 1'b0;
    result_r  = 1'b0;
    wr_addr_r = wr_ptr_q;
    rd_addr_r = AW'(fir_wrap_sub(32'(wr_ptr_q), 32'(tap_q),
                                 FIR_DEPTH));
    unique case (state_q)
      CLEAR: begin
        wr_en_r   = 1'b1;
        wr_zero_r = 1'b1;
        wr_addr_r = tap_q;
      end
      IDLE: begin
        ready_r = 1'b1;
      end
      WRITE: begin
        wr_en_r = 1'b1;
      end
      ISSUE: begin
        issue_r = 1'b1;
      end
      DRAIN: begin
        ready_r = 1'b0;
      end
      DONE: begin
        ready_r  = 1'b1;
        result_r = 1'b1;
      end
      default: begin
        ready_r = 1'b0;
      end
    endcase
  end

  fir_seq_delay_pipe #(
    .MAC_LATENCY(MAC_LATENCY)
  ) u_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_issue(issue_r),
    .i_first(first_tap),
    .o_issue(pipe_issue),
    .o_first(pipe_first),
    .o_busy (pipe_busy)
  );

  assign o_ready        = ready_r & ~i_rst;
  assign o_wr_en        = wr_en_r & gate;
  assign o_wr_zero      = wr_zero_r & gate;
  assign o_wr_addr      = wr_addr_r;
  assign o_issue        = issue_r & gate;
  assign o_rd_addr      = rd_addr_r;
  assign o_coef_addr    = tap_q;
  assign o_mac_clr      = pipe_first & gate;
  assign o_mac_en       = pipe_issue & gate;
  assign o_result_valid = result_r & gate;

`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
  logic       vld_q;
  logic       ovr_q;
  logic [7:0] ovr_cnt_q;

  // A new sample edge while the block cannot accept it is an overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q     <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else if (i_en) begin
      vld_q <= i_sample_valid;
      if (i_sample_valid && !vld_q && !ready_r) begin
        ovr_q <= 1'b1;
        if (ovr_cnt_q != 8'hFF) begin
          ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
      end
    end
  end

  assign o_overrun     = ovr_q;
  assign o_overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed table-driven bench for fir_mac_sequencer.
// Per-cycle expected strobes/addresses are built from the frame timing.
module tb_fir_mac_sequencer;

  localparam int D   = 16;
  localparam int LAT = 3;
  localparam int DW  = 24;

  logic       clk;
  logic       rst;
  logic       en;
  logic       valid;
  logic       ready;
  logic       wr_en;
  logic       wr_zero;
  logic [3:0] wr_addr;
  logic       issue;
  logic [3:0] rd_addr;
  logic [3:0] coef_addr;
  logic       mac_clr;
  logic       mac_en;
  logic       res_v;
`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
  logic       ovr;
  logic [7:0] ovr_cnt;
`endif

  fir_mac_sequencer #(
    .DATA_WIDTH (DW),
    .FIR_DEPTH  (D),
    .MAC_LATENCY(LAT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_sample_valid(valid),
    .o_ready       (ready),
    .o_wr_en       (wr_en),
    .o_wr_zero     (wr_zero),
    .o_wr_addr     (wr_addr),
    .o_issue       (issue),
    .o_rd_addr     (rd_addr),
    .o_coef_addr   (coef_addr),
    .o_mac_clr     (mac_clr),
    .o_mac_en      (mac_en),
    .o_result_valid(res_v)
`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
    ,
    .o_overrun     (ovr),
    .o_overrun_cnt (ovr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strb = {ready, wr_en, wr_zero, issue, mac_clr, mac_en, result_valid}
  typedef struct {
    bit         valid;
    bit         en;
    bit         rst;
    logic [6:0] strb;
    int         wa;
    int         ra;
    int         ca;
  } vec_t;

  vec_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic [6:0] strb_a;
  assign strb_a = {ready, wr_en, wr_zero, issue, mac_clr, mac_en, res_v};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] mk(bit rd, bit we, bit wz, bit is,
                                    bit cl, bit me, bit rv);
    return {rd, we, wz, is, cl, me, rv};
  endfunction

  function automatic void push(bit v, bit e, bit r, logic [6:0] s,
                               int wa, int ra, int ca);
    vec_t x;
    x.valid = v;
    x.en    = e;
    x.rst   = r;
    x.strb  = s;
    x.wa    = wa;
    x.ra    = ra;
    x.ca    = ca;
    q.push_back(x);
  endfunction

  // nrst reset cycles, then the D-cycle zeroing pass, then one IDLE cycle.
  function automatic void push_clear(int nrst);
    for (int i = 0; i < nrst; i++)
      push(0, 1, 1, 7'b0, -1, -1, -1);
    for (int i = 0; i < D; i++)
      push(0, 1, 0, mk(0, 1, 1, 0, 0, 0, 0), i, -1, -1);
    push(0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0), -1, -1, -1);
  endfunction

  // One frame, accept at p=0, up to the cycle before result_valid.
  function automatic void push_frame(int wp, bit pd, bit hold, int fz_at,
                                     int fz_len, int abort_at, bit pulses);
    for (int p = 0; p <= D + LAT + 1 + fz_len; p++) begin
      int         lc;
      bit         fz;
      bit         v;
      bit         isu;
      logic [6:0] s;
      int         wa;
      int         ra;
      int         ca;
      if (abort_at >= 0 && p >= abort_at) break;
      fz = 0;
      lc = p;
      if (fz_at >= 0 && p >= fz_at) begin
        if (p < fz_at + fz_len) begin
          lc = fz_at;
          fz = 1;
        end else begin
          lc = p - fz_len;
        end
      end
      v   = (p == 0) || hold || (pulses && (p == 4 || p == 6 || p == 8));
      isu = (lc >= 2) && (lc <= D + 1);
      s   = mk(lc == 0, lc == 1, 0, isu, lc == 2 + LAT,
               (lc >= 2 + LAT) && (lc <= D + 1 + LAT), (lc == 0) && pd);
      if (fz) s = s & 7'b1000000;
      wa = (lc == 1) ? wp : -1;
      ra = isu ? (((wp - (lc - 2)) % D) + D) % D : -1;
      ca = isu ? lc - 2 : -1;
      push(v, !fz, 0, s, wa, ra, ca);
    end
  endfunction

  function automatic void push_tail(bit v);
    push(v, 1, 0, mk(1, 0, 0, 0, 0, 0, 1), -1, -1, -1);
  endfunction

  function automatic void push_idle(int n);
    for (int i = 0; i < n; i++)
      push(0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0), -1, -1, -1);
  endfunction

  // Entered at posedge+1; drives, samples at +2, advances one clock.
  task automatic run_table();
    for (int i = 0; i < q.size(); i++) begin
      valid = q[i].valid;
      en    = q[i].en;
      rst   = q[i].rst;
      #1;
      chk("strobes", 32'(strb_a), 32'(q[i].strb));
      if (q[i].wa >= 0) chk("wr_addr", 32'(wr_addr), q[i].wa);
      if (q[i].ra >= 0) chk("rd_addr", 32'(rd_addr), q[i].ra);
      if (q[i].ca >= 0) chk("coef_addr", 32'(coef_addr), q[i].ca);
      @(posedge clk);
      #1;
      cyc++;
    end
    q.delete();
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset state and the zeroing pass.
    push_clear(2);
    run_table();

    // Single frame at write pointer 0.
    push_frame(0, 0, 0, -1, 0, -1, 0);
    push_tail(0);
    push_idle(2);
    run_table();

    // 17 back-to-back frames from a fresh pointer; last one wraps to 0.
    push_clear(2);
    for (int f = 0; f < 17; f++)
      push_frame(f % D, f > 0, 1, -1, 0, -1, 0);
    push_tail(0);
    push_idle(1);
    run_table();

    // Freeze for 5 cycles at frame cycle 8.
    push_frame(1, 0, 0, 8, 5, -1, 0);
    push_tail(0);
    push_idle(1);
    run_table();

    // Reset at frame cycle 10, then clear pass and restart at address 0.
    push_frame(2, 0, 0, -1, 0, 10, 0);
    push_clear(1);
    run_table();
`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
    chk("overrun_clr", 32'(ovr), 32'd0);
    chk("overrun_cnt_clr", 32'(ovr_cnt), 32'd0);
`endif
    push_frame(0, 0, 0, -1, 0, -1, 0);
    push_tail(0);
    push_idle(1);
    run_table();

    // Valid pulsed three times during ISSUE; frame must be unaffected.
    push_frame(1, 0, 0, -1, 0, -1, 1);
    push_tail(0);
    push_idle(1);
    run_table();
`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
    chk("overrun", 32'(ovr), 32'd1);
    chk("overrun_cnt", 32'(ovr_cnt), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
